mosi_channel_sequencer: RTL and testbench
=========================================

MOSI_CHANNEL_SEQUENCER -- requirements
Module: mosi_channel_sequencer

Interface
REQ-001 Parameter LAST_SLOT, default 34, is the index of the final command slot of one sample frame: slots 0-31 are CONVERT, slots 32-34 are aux.
REQ-002 Parameter IDX_W, default 10, is the width of each aux command index.
REQ-003 dataclk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 run_start  in  1  one-cycle pulse requesting a new acquisition run.
REQ-006 run_continuous  in  1  1 = ignore max_timestep and run until stopped.
REQ-007 stop_request  in  1  one-cycle pulse: finish the current sample frame, then go idle.
REQ-008 max_timestep  in  32  number of sample frames per non-continuous run.
REQ-009 slot_done  in  1  one-cycle pulse from the SPI shifter: the issued slot has completed.
REQ-010 aux_end_index  in  3*IDX_W  per aux slot {s3,s2,s1}: last index before wrap.
REQ-011 aux_loop_index  in  3*IDX_W  per aux slot {s3,s2,s1}: index reloaded after the end index.
REQ-012 channel  out  6  slot number driven to the MOSI command selectors.
REQ-013 slot_valid  out  1  one-cycle pulse: channel is stable, start shifting.
REQ-014 aux_index  out  3*IDX_W  current aux command RAM address per aux slot.
REQ-015 timestamp  out  32  count of completed sample frames in the current run.
REQ-016 sample_done  out  1  one-cycle pulse when slot LAST_SLOT completes.
REQ-017 running  out  1  1 in any state other than IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT.
REQ-019 IDLE: on run_start with (run_continuous=1 or max_timestep!=0), the FSM SHALL go to ISSUE and load channel=0, timestamp=0, aux_index=0 and stop_pending=0; otherwise it SHALL stay in IDLE.
REQ-020 ISSUE: slot_valid=1 for exactly this cycle, then the FSM SHALL go unconditionally to WAIT; the first slot_valid therefore comes 1 cycle after run_start.
REQ-021 WAIT: the FSM SHALL hold channel stable until slot_done=1.
REQ-022 WAIT with slot_done=1 and channel<LAST_SLOT: channel SHALL be set to channel+1 and the FSM SHALL go to ISSUE.
REQ-023 WAIT with slot_done=1 and channel==LAST_SLOT: the block SHALL pulse sample_done, increment timestamp (wrapping modulo 2^32) and set channel=0.
REQ-024 In the same cycle as REQ-023, each aux_index[k] SHALL advance: to aux_loop_index[k] if it equals aux_end_index[k], else to aux_index[k]+1 (wrapping modulo 2^IDX_W).
REQ-025 After REQ-023, the FSM SHALL go to IDLE if stop_pending=1, or if run_continuous=0 and the new timestamp equals max_timestep; otherwise it SHALL go to ISSUE.
REQ-026 A stop_request in ISSUE or WAIT SHALL set stop_pending; it is cleared only on run start; a stop_request in IDLE SHALL be ignored.
REQ-027 A stop_request coincident with the final slot_done SHALL take effect at that frame end.
REQ-028 slot_done SHALL be ignored in IDLE and ISSUE; run_start SHALL be ignored outside IDLE.
REQ-029 run_continuous SHALL be sampled only at frame end, so a change mid-frame has no effect until the frame completes.
REQ-030 timestamp and aux_index SHALL hold their last values in IDLE until the next run start.
REQ-031 All outputs SHALL be registered; no output may depend combinationally on any input.

Reset
REQ-032 reset=1 SHALL force IDLE, channel=0, slot_valid=0, sample_done=0, running=0, timestamp=0, aux_index=0 and stop_pending=0 on the next edge.
REQ-033 reset SHALL override every other input, including when asserted mid-frame.

Verification
REQ-034 max_timestep=2, run_continuous=0, run_start, slot_done 3 cycles after each slot_valid -> channel sequence 0..34 twice, 2 sample_done pulses, timestamp=2, then IDLE with running=0.
REQ-035 aux_end_index slot1=2, aux_loop_index slot1=1, 5 frames -> aux_index slot1 follows 0,1,2,1,2,1.
REQ-036 run_continuous=1, stop_request at channel 10 of frame 3 -> frame 3 completes through channel 34, timestamp=4, then IDLE.
REQ-037 max_timestep=0, run_continuous=0, run_start -> no slot_valid pulse and running stays 0.
REQ-038 reset asserted in WAIT at channel 20 -> next cycle IDLE, channel=0, timestamp=0; a later slot_done produces no effect.
REQ-039 run_start and spurious slot_done pulses during ISSUE or mid-frame -> no channel skip and no restart.

Source files
------------

// File: rtl/mosi_channel_sequencer.sv
// Steps the MOSI command selector through the CONVERT and aux slots of each sample frame,
// handing one slot at a time to the SPI shifter and tracking frame count and aux RAM addresses.
module mosi_channel_sequencer #(
    parameter int LAST_SLOT = 34,
    parameter int IDX_W     = 10
) (
    input  logic                 dataclk,
    input  logic                 reset,
    input  logic                 run_start,
    input  logic                 run_continuous,
    input  logic                 stop_request,
    input  logic [31:0]          max_timestep,
    input  logic                 slot_done,
    input  logic [3*IDX_W-1:0]   aux_end_index,
    input  logic [3*IDX_W-1:0]   aux_loop_index,
    output logic [5:0]           channel,
    output logic                 slot_valid,
    output logic [3*IDX_W-1:0]   aux_index,
    output logic [31:0]          timestamp,
    output logic                 sample_done,
    output logic                 running
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]         r_state;
    logic [5:0]         r_channel;
    logic [3*IDX_W-1:0] r_aux_index;
    logic [31:0]        r_timestamp;
    logic               r_sample_done;
    logic               r_stop_pending;

    logic [3*IDX_W-1:0] w_aux_next;
    logic [31:0]        w_ts_next;
    logic               w_last_slot;
    logic               w_frame_stop;

    always_comb begin
        w_aux_next = r_aux_index;
        for (int k = 0; k < 3; k++) begin
            if (r_aux_index[k*IDX_W +: IDX_W] == aux_end_index[k*IDX_W +: IDX_W])
                w_aux_next[k*IDX_W +: IDX_W] = aux_loop_index[k*IDX_W +: IDX_W];
            else
                w_aux_next[k*IDX_W +: IDX_W] = r_aux_index[k*IDX_W +: IDX_W] + 1'b1;
        end
    end

    assign w_ts_next    = r_timestamp + 32'd1;
    assign w_last_slot  = (r_channel == 6'(LAST_SLOT));
    // A stop arriving with the final slot_done still ends the run at this frame boundary.
    assign w_frame_stop = r_stop_pending | stop_request |
                          (!run_continuous && (w_ts_next == max_timestep));

    always_ff @(posedge dataclk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_channel      <= 6'd0;
            r_aux_index    <= '0;
            r_timestamp    <= 32'd0;
            r_sample_done  <= 1'b0;
            r_stop_pending <= 1'b0;
        end else begin
            r_sample_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (run_start && (run_continuous || (max_timestep != 32'd0))) begin
                        r_state        <= ISSUE;
                        r_channel      <= 6'd0;
                        r_timestamp    <= 32'd0;
                        r_aux_index    <= '0;
                        r_stop_pending <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                    if (stop_request)
                        r_stop_pending <= 1'b1;
                end
                WAIT: begin
                    if (stop_request)
                        r_stop_pending <= 1'b1;
                    if (slot_done) begin
                        if (!w_last_slot) begin
                            r_channel <= r_channel + 6'd1;
                            r_state   <= ISSUE;
                        end else begin
                            r_sample_done <= 1'b1;
                            r_timestamp   <= w_ts_next;
                            r_channel     <= 6'd0;
                            r_aux_index   <= w_aux_next;
                            r_state       <= w_frame_stop ? IDLE : ISSUE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign channel     = r_channel;
    assign slot_valid  = (r_state == ISSUE);
    assign aux_index   = r_aux_index;
    assign timestamp   = r_timestamp;
    assign sample_done = r_sample_done;
    assign running     = (r_state != IDLE);

endmodule

// File: tb/tb_mosi_channel_sequencer.sv
// Directed bench for mosi_channel_sequencer: a bench-side shifter answers each slot_valid
// with slot_done three cycles later while channel, frame-end and aux values are checked.
module tb_mosi_channel_sequencer;

    localparam int LAST  = 34;
    localparam int IDX_W = 10;

    logic                 dataclk = 1'b0;
    logic                 reset = 1'b1;
    logic                 run_start = 1'b0;
    logic                 run_continuous = 1'b0;
    logic                 stop_request = 1'b0;
    logic [31:0]          max_timestep = 32'd0;
    logic                 slot_done = 1'b0;
    logic [3*IDX_W-1:0]   aux_end_index = '0;
    logic [3*IDX_W-1:0]   aux_loop_index = '0;
    logic [5:0]           channel;
    logic                 slot_valid;
    logic [3*IDX_W-1:0]   aux_index;
    logic [31:0]          timestamp;
    logic                 sample_done;
    logic                 running;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ch   = 0;
    int exp_f    = 0;

    // Expected aux slot1 after frames 1..5 with end=2, loop=1.
    int exp_aux1 [5] = '{1, 2, 1, 2, 1};

    mosi_channel_sequencer #(.LAST_SLOT(LAST), .IDX_W(IDX_W)) dut (
        .dataclk        (dataclk),
        .reset          (reset),
        .run_start      (run_start),
        .run_continuous (run_continuous),
        .stop_request   (stop_request),
        .max_timestep   (max_timestep),
        .slot_done      (slot_done),
        .aux_end_index  (aux_end_index),
        .aux_loop_index (aux_loop_index),
        .channel        (channel),
        .slot_valid     (slot_valid),
        .aux_index      (aux_index),
        .timestamp      (timestamp),
        .sample_done    (sample_done),
        .running        (running)
    );

    always #5 dataclk = ~dataclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge dataclk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_run();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        exp_ch = 0;
        exp_f  = 0;
    endtask

    // Plays the SPI shifter for nslots slots; stop_c==LAST makes the stop coincide with the final slot_done.
    task automatic serve(input int nslots, input int stop_f, input int stop_c,
                         input bit spur, input bit auxchk);
        for (int s = 0; s < nslots; s++) begin
            int w;
            bit hit;
            w = 0;
            while (slot_valid !== 1'b1 && w < 10) begin
                tick();
                w++;
            end
            check_eq("slot_valid_wait", slot_valid, 1'b1);
            if (slot_valid !== 1'b1) return;
            check_eq("channel", channel, exp_ch);
            hit = (exp_f == stop_f) && (exp_ch == stop_c);
            if (spur && (s % 7 == 3)) begin
                slot_done = 1'b1;
                run_start = 1'b1;
            end
            tick();
            slot_done = 1'b0;
            run_start = 1'b0;
            if (hit && stop_c != LAST) stop_request = 1'b1;
            tick();
            stop_request = 1'b0;
            if (spur && (s % 7 == 3)) run_start = 1'b1;
            tick();
            run_start = 1'b0;
            check_eq("channel_hold", channel, exp_ch);
            slot_done = 1'b1;
            if (hit && stop_c == LAST) stop_request = 1'b1;
            tick();
            slot_done = 1'b0;
            stop_request = 1'b0;
            check_eq("sample_done", sample_done, exp_ch == LAST);
            if (exp_ch == LAST) begin
                exp_f++;
                exp_ch = 0;
                check_eq("timestamp", timestamp, exp_f);
                if (auxchk && exp_f <= 5)
                    check_eq("aux_index", aux_index, {10'(exp_f), 10'd0, 10'(exp_aux1[exp_f-1])});
            end else begin
                exp_ch++;
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check_eq("rst_channel", channel, 0);
        check_eq("rst_slot_valid", slot_valid, 0);
        check_eq("rst_sample_done", sample_done, 0);
        check_eq("rst_running", running, 0);
        check_eq("rst_timestamp", timestamp, 0);
        check_eq("rst_aux", aux_index, 0);
        reset = 1'b0;
        tick();

        // Two-frame bounded run
        max_timestep = 32'd2;
        run_continuous = 1'b0;
        start_run();
        check_eq("first_slot_valid", slot_valid, 1);
        check_eq("run_running", running, 1);
        serve(2*(LAST+1), -1, -1, 1'b0, 1'b0);
        check_eq("run1_ts", timestamp, 2);
        check_eq("run1_running", running, 0);
        tick();
        check_eq("run1_sd_pulse", sample_done, 0);
        check_eq("run1_idle_sv", slot_valid, 0);

        // Aux index looping over five frames
        aux_end_index  = {10'd1023, 10'd0, 10'd2};
        aux_loop_index = {10'd5, 10'd0, 10'd1};
        max_timestep = 32'd5;
        start_run();
        check_eq("aux_start", aux_index, 0);
        serve(5*(LAST+1), -1, -1, 1'b0, 1'b1);
        check_eq("aux_run_running", running, 0);
        repeat (4) tick();
        check_eq("idle_hold_ts", timestamp, 5);
        check_eq("idle_hold_aux", aux_index, {10'd5, 10'd0, 10'd1});

        // Continuous run stopped mid-frame 3
        run_continuous = 1'b1;
        max_timestep = 32'd1;
        start_run();
        check_eq("cont_ts0", timestamp, 0);
        serve(4*(LAST+1), 3, 10, 1'b0, 1'b0);
        check_eq("stop_ts", timestamp, 4);
        check_eq("stop_running", running, 0);

        // Stop coincident with the final slot_done
        start_run();
        serve(LAST+1, 0, LAST, 1'b0, 1'b0);
        check_eq("coinc_ts", timestamp, 1);
        check_eq("coinc_running", running, 0);

        // Zero-length bounded run never starts
        run_continuous = 1'b0;
        max_timestep = 32'd0;
        start_run();
        for (int i = 0; i < 4; i++) begin
            check_eq("zero_sv", slot_valid, 0);
            check_eq("zero_running", running, 0);
            tick();
        end

        // Spurious run_start / slot_done pulses
        max_timestep = 32'd2;
        start_run();
        serve(2*(LAST+1), -1, -1, 1'b1, 1'b0);
        check_eq("spur_ts", timestamp, 2);
        check_eq("spur_running", running, 0);

        // Reset in WAIT at channel 20
        aux_end_index  = {10'd0, 10'd0, 10'd2};
        aux_loop_index = {10'd0, 10'd0, 10'd1};
        run_continuous = 1'b1;
        start_run();
        serve(LAST+1+20, -1, -1, 1'b0, 1'b0);
        check_eq("pre_rst_sv", slot_valid, 1);
        tick();
        check_eq("pre_rst_ch", channel, 20);
        check_eq("pre_rst_aux", aux_index, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_running", running, 0);
        check_eq("mid_rst_channel", channel, 0);
        check_eq("mid_rst_ts", timestamp, 0);
        check_eq("mid_rst_aux", aux_index, 0);
        slot_done = 1'b1;
        tick();
        slot_done = 1'b0;
        tick();
        check_eq("post_rst_running", running, 0);
        check_eq("post_rst_sv", slot_valid, 0);
        check_eq("post_rst_sd", sample_done, 0);
        check_eq("post_rst_channel", channel, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
